alu_seq_muldiv: RTL and testbench

Parametrised successor to the single-cycle integer ALU.
- Executes all base RV32I ALU operations plus the RV32M multiply/divide/remainder set.
- Width is generic and the result is registered.
- Uses an in/out valid-ready handshake, so the multi-cycle execute stage can stall the pipeline.
- Base ops complete in 1 cycle. Multiply and divide run as iterative XLEN-step engines.

---
 rtl/alu_seq_muldiv.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_muldiv.sv
// Sequential RV32I/RV32M integer ALU with in/out valid-ready handshake; optional macro ALU_FAST_MUL_EN.
// Latency: base/illegal ops 1 cycle, mul/div XLEN+1 cycles (mul 2 cycles with ALU_FAST_MUL_EN).
// Backpressure: result held in DONE until out_ready; in_ready is low in BUSY and DONE.
module alu_seq_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_ans,
  output logic            zero,
  output logic            busy
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [4:0]          op_q;
  logic [XLEN-1:0]     a_q;        // original dividend, returned by rem-by-zero
  logic                bzero_q;    // divisor was zero
  logic [XLEN-1:0]     acc_hi;     // mul: upper partial product / div: partial remainder
  logic [XLEN-1:0]     acc_lo;     // mul: multiplier, shifting out / div: dividend -> quotient
  logic [XLEN-1:0]     mag_b;      // magnitude of multiplicand or divisor
  logic                neg_res;    // negate product / quotient at the end
  logic                neg_rem;    // negate remainder at the end
  logic [SHW-1:0]      cnt;

  // Accept-time decode
  logic                is_md, is_base, op_is_mul;
  logic                sign_a, sign_b;
  logic [XLEN-1:0]     mag_a_in, mag_b_in;
  logic [XLEN-1:0]     base_res;
  logic                base_zero;
  logic [SHW-1:0]      shamt;
  logic signed [XLEN-1:0] src1_s;

  // Iteration / final result
  logic [XLEN:0]       mul_sum, div_sh, div_diff;
  logic [XLEN-1:0]     nhi, nlo, quo, rmd;
  logic [2*XLEN-1:0]   prod_raw, prod_fix;
  logic [XLEN-1:0]     fin_res;
  logic                fin_zero;
  logic                last_step;

  assign is_md     = (alu_control >= OP_MUL) && (alu_control <= OP_REMU);
  assign is_base   = (alu_control <= OP_SLTU);
  assign op_is_mul = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
  assign shamt     = src2[SHW-1:0];
  assign src1_s    = src1;

  // Signed operands are taken as magnitudes; the sign is restored in the final cycle
  always_comb begin
    sign_a   = src1[XLEN-1] && (alu_control == OP_MULH || alu_control == OP_MULHSU ||
                                alu_control == OP_DIV  || alu_control == OP_REM);
    sign_b   = src2[XLEN-1] && (alu_control == OP_MULH || alu_control == OP_DIV ||
                                alu_control == OP_REM);
    mag_a_in = sign_a ? -src1 : src1;
    mag_b_in = sign_b ? -src2 : src2;
  end

  // Single-cycle base operations; illegal opcodes give 0 with zero low
  always_comb begin
    base_res = '0;
    case (alu_control)
      OP_ADD:  base_res = src1 + src2;
      OP_SUB:  base_res = src1 - src2;
      OP_AND:  base_res = src1 & src2;
      OP_OR:   base_res = src1 | src2;
      OP_XOR:  base_res = src1 ^ src2;
      OP_SLL:  base_res = src1 << shamt;
      OP_SRL:  base_res = src1 >> shamt;
      OP_SRA:  base_res = src1_s >>> shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      default: base_res = '0;
    endcase
    // For slt/sltu the result is 0/1, so result==0 is exactly the inverted compare
    base_zero = is_base && (base_res == '0);
  end

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + ({1'b0, mag_b} & {(XLEN+1){acc_lo[0]}});
    div_sh   = {acc_hi, acc_lo[XLEN-1]};
    div_diff = div_sh - {1'b0, mag_b};
    if (op_is_mul) begin
      nhi = mul_sum[XLEN:1];
      nlo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      nhi = div_diff[XLEN-1:0];
      nlo = {acc_lo[XLEN-2:0], 1'b1};
    end else begin
      nhi = div_sh[XLEN-1:0];
      nlo = {acc_lo[XLEN-2:0], 1'b0};
    end
  end

`ifdef ALU_FAST_MUL_EN
  assign prod_raw  = {{XLEN{1'b0}}, acc_lo} * {{XLEN{1'b0}}, mag_b};
  assign last_step = op_is_mul || (cnt == SHW'(XLEN-1));
`else
  assign prod_raw  = {nhi, nlo};
  assign last_step = (cnt == SHW'(XLEN-1));
`endif

  // Sign fix-up and divide corner cases, applied as the last step completes
  always_comb begin
    prod_fix = neg_res ? -prod_raw : prod_raw;
    quo      = neg_res ? -nlo : nlo;
    rmd      = neg_rem ? -nhi : nhi;
    fin_res  = '0;
    case (op_q)
      OP_MUL:                       fin_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = bzero_q ? '1 : quo;
      OP_REM, OP_REMU:              fin_res = bzero_q ? a_q : rmd;
      default:                      fin_res = '0;
    endcase
    fin_zero = (fin_res == '0);
  end

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      alu_ans   <= '0;
      zero      <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      bzero_q   <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      mag_b     <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= alu_control;
            in_ready <= 1'b0;
            if (is_md) begin
              state   <= BUSY;
              busy    <= 1'b1;
              cnt     <= '0;
              acc_hi  <= '0;
              acc_lo  <= mag_a_in;
              mag_b   <= mag_b_in;
              neg_res <= sign_a ^ sign_b;
              neg_rem <= sign_a;
              a_q     <= src1;
              bzero_q <= (src2 == '0);
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              alu_ans   <= base_res;
              zero      <= base_zero;
            end
          end
        end
        BUSY: begin
          acc_hi <= nhi;
          acc_lo <= nlo;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            alu_ans   <= fin_res;
            zero      <= fin_zero;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Bench for alu_seq_muldiv: directed test-plan steps followed by random ops
// checked against an arithmetic reference model (results, zero flag, latency).
module tb_alu_seq_muldiv;

  localparam int XLEN = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_control = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_ans;
  logic        zero;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ans(alu_ans),
    .zero(zero), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32I/M semantics in 64-bit arithmetic
  function automatic logic [31:0] ref_ans(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] as32, bs32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    as32 = a;
    bs32 = b;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'(as32 >>> b[4:0]);
      5'd8:  return {31'b0, (as32 < bs32)};
      5'd9:  return {31'b0, (a < b)};
      5'd10: begin p = sa * sb; return p[31:0]; end
      5'd11: begin p = sa * sb; return p[63:32]; end
      5'd12: begin p = sa * $signed(ub); return p[63:32]; end
      5'd13: begin up = ua * ub; return up[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(as32 / bs32);
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(as32 % bs32);
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op);
    if (op >= 10 && op <= 13) return MUL_LAT;
    if (op >= 14 && op <= 17) return XLEN + 1;
    return 1;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Present a request at a negedge; it is accepted at the following posedge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("issue_ready_timeout", 0, 1);
    alu_control = op;
    src1        = a;
    src2        = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts negedges from accept until out_valid, and how many of them saw busy
  task automatic wait_out(output int lat, output int bcy);
    lat = 0;
    bcy = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcy++;
      if (out_valid) break;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("ack_out_valid_low", out_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] got);
    int lat, bcy;
    logic [31:0] exp;
    issue(op, a, b);
    wait_out(lat, bcy);
    exp = ref_ans(op, a, b);
    check($sformatf("%s_ans", tag), alu_ans, exp);
    check($sformatf("%s_zero", tag), zero, (op > 17) ? 1'b0 : (exp == 0));
    check($sformatf("%s_lat", tag), lat, ref_lat(op));
    check($sformatf("%s_busy", tag), bcy, ref_lat(op) - 1);
    check($sformatf("%s_in_ready", tag), in_ready, 0);
    got = alu_ans;
    ack();
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        plan[$];
    logic [31:0] got, held;
    int          lat, bcy, seen;

    // Reset held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_ans", alu_ans, 0);
    check("rst_zero", zero, 0);
    check("rst_busy", busy, 0);

    // Test-plan vectors with hand-derived results
    plan.push_back('{5'd0,  32'hFFFF_FFFF, 32'h1,         32'h0});
    plan.push_back('{5'd7,  32'h8000_0000, 32'h21,        32'hC000_0000});
    plan.push_back('{5'd8,  32'hFFFF_FFFF, 32'h1,         32'h1});
    plan.push_back('{5'd9,  32'hFFFF_FFFF, 32'h1,         32'h0});
    plan.push_back('{5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    plan.push_back('{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    plan.push_back('{5'd10, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB});
    plan.push_back('{5'd14, 32'h7,         32'h0,         32'hFFFF_FFFF});
    plan.push_back('{5'd16, 32'h7,         32'h0,         32'h7});
    plan.push_back('{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    plan.push_back('{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
    plan.push_back('{5'd16, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF});
    plan.push_back('{5'd15, 32'd100,       32'd7,         32'd14});
    plan.push_back('{5'd20, 32'h1234_5678, 32'h1,         32'h0});
    foreach (plan[i]) begin
      run_op($sformatf("plan%0d", i), plan[i].op, plan[i].a, plan[i].b, got);
      check($sformatf("plan%0d_const", i), got, plan[i].exp);
    end

    // Backpressure: result held for 10 cycles while a new request is offered
    issue(5'd14, 32'd100, 32'd7);
    wait_out(lat, bcy);
    check("bp_lat", lat, XLEN + 1);
    check("bp_ans", alu_ans, 32'd14);
    held        = alu_ans;
    alu_control = 5'd0;
    src1        = 32'd2;
    src2        = 32'd3;
    in_valid    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", i), out_valid, 1);
      check($sformatf("bp_hold%0d", i), alu_ans, held);
      check($sformatf("bp_in_ready%0d", i), in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_ignored_request", seen, 0);

    // Abort a divu with reset partway through
    issue(5'd15, 32'hFFFF_FFFF, 32'd3);
    repeat (10) @(negedge clk);
    check("abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy_low", busy, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    run_op("abort_add", 5'd0, 32'd2, 32'd3, got);
    check("abort_add_const", got, 32'd5);

    // Random operations against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, pick_val(), pick_val(), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
